// File: rtl/ten_pkg.sv
// Shared constants, operand type and the elaboration-time primality function.
package ten_pkg;

   localparam int TEN_WIDTH = 5;
   localparam int TEN_CNT_W = 16;

   typedef logic [TEN_WIDTH-1:0] operand_t;

   // Trial division; only evaluated on constants when the lookup table is built.
   function automatic logic is_prime(input int n);
      if (n < 2) return 1'b0;
      for (int d = 2; d * d <= n; d++) begin
         if (n % d == 0) return 1'b0;
      end
      return 1'b1;
   endfunction

endpackage

// File: rtl/ten_prime_rom.sv
// Combinational primality lookup over a 2^WIDTH-entry constant table.
module ten_prime_rom
   import ten_pkg::*;
#(
   parameter int WIDTH = TEN_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   output logic             prime
);

   localparam int DEPTH = 2 ** WIDTH;

   logic [DEPTH-1:0] rom_bits;

   // One constant bit per possible operand; nothing here exists at runtime but the mux.
   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      assign rom_bits[i] = is_prime(i);
   end

   assign prime = rom_bits[a];

endmodule

// File: rtl/ten_unit.sv
// Registered prime detector: 1-cycle latency flag, valid strobe and saturating hit count.
module ten_unit
   import ten_pkg::*;
#(
   parameter int WIDTH = TEN_WIDTH,
   parameter int CNT_W = TEN_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic             A_valid,
   output logic             P,
   output logic             P_valid,
   output logic [CNT_W-1:0] prime_cnt
);

   logic             raw_prime;
   logic             p_q;
   logic             vld_q;
   logic [CNT_W-1:0] cnt_q;

   ten_prime_rom #(.WIDTH(WIDTH)) u_rom (
      .a     (A),
      .prime (raw_prime)
   );

   // Flag register: only an accepted operand updates P, so a floating A while idle never reaches it.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_q   <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= A_valid;
         if (A_valid) p_q <= raw_prime;
      end
   end

   // Hit counter: counts accepted primes and sticks at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (A_valid && raw_prime && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign P         = p_q;
   assign P_valid   = vld_q;
   assign prime_cnt = cnt_q;

endmodule

// File: tb/tb_ten_unit.sv
// Scoreboard bench for ten_unit: driver pushes model expectations, monitor pops and compares.
module tb_ten_unit;
   import ten_pkg::*;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   operand_t       A = '0;
   logic           A_valid = 1'b0;
   logic           P, P_valid, P2, P_valid2;
   logic [15:0]    prime_cnt;
   logic [1:0]     prime_cnt2;

   typedef struct {
      logic        p;
      logic        p_valid;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference state
   logic        m_p = 1'b0;
   logic        m_v = 1'b0;
   int          m_cnt = 0;
   int          m_cnt2 = 0;

   always #5 clk = ~clk;

   ten_unit #(.WIDTH(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .A(A), .A_valid(A_valid),
      .P(P), .P_valid(P_valid), .prime_cnt(prime_cnt)
   );

   ten_unit #(.WIDTH(5), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .A(A), .A_valid(A_valid),
      .P(P2), .P_valid(P_valid2), .prime_cnt(prime_cnt2)
   );

   // A prime has exactly two divisors in 1..n.
   function automatic logic ref_prime(input int n);
      int divs = 0;
      for (int d = 1; d <= n; d++) if (n % d == 0) divs++;
      return divs == 2;
   endfunction

   task automatic cyc(input logic r, input logic v, input int a, input string tag);
      exp_t e;
      @(negedge clk);
      rst     = r;
      A_valid = v;
      A       = operand_t'(a);
      if (r) begin
         m_p = 1'b0; m_v = 1'b0; m_cnt = 0; m_cnt2 = 0;
      end else if (v) begin
         m_p = ref_prime(a);
         m_v = 1'b1;
         if (m_p) begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
            m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
         end
      end else begin
         m_v = 1'b0;
      end
      e.p = m_p; e.p_valid = m_v; e.cnt = 16'(m_cnt); e.cnt2 = 2'(m_cnt2); e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: one expectation per clock edge, sampled just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".P_valid"},   int'(P_valid),    int'(e.p_valid));
            chk({e.tag, ".P"},         int'(P),          int'(e.p));
            chk({e.tag, ".prime_cnt"}, int'(prime_cnt),  int'(e.cnt));
            chk({e.tag, ".sat_cnt"},   int'(prime_cnt2), int'(e.cnt2));
            chk({e.tag, ".sat_P"},     int'(P2),         int'(e.p));
         end
      end
   end

   initial begin
      int budget;
      // reset with a valid prime present: rst wins
      cyc(1'b1, 1'b1, 7, "reset0");
      cyc(1'b1, 1'b1, 7, "reset1");
      // exhaustive sweep
      for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, i, $sformatf("sweep%0d", i));
      cyc(1'b0, 1'b0, 0, "idle");
      // boundaries
      cyc(1'b0, 1'b1, 0,  "b0");
      cyc(1'b0, 1'b1, 1,  "b1");
      cyc(1'b0, 1'b1, 2,  "b2");
      cyc(1'b0, 1'b1, 31, "b31");
      cyc(1'b0, 1'b1, 25, "b25");
      // valid gating
      cyc(1'b0, 1'b0, 13, "gate_off");
      cyc(1'b0, 1'b1, 13, "gate_on");
      // mid-stream reset
      cyc(1'b0, 1'b1, 29, "mid_acc");
      cyc(1'b1, 1'b1, 29, "mid_rst");
      cyc(1'b0, 1'b1, 4,  "post4");
      // random traffic, idle cycles carry garbage on A
      for (int i = 0; i < 400; i++)
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
             int'($urandom_range(0, 31)), "rnd");
      cyc(1'b0, 1'b0, 0, "drain");
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #2;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ten_unit.md
Name: ten_unit

Overview:
- Registered 5-bit prime detector, parameterized by input width.
- Each cycle it samples operand A and asserts P one cycle later when A is a prime number.
- It is a leaf block for combinational-exercise datapaths. Downstream logic consumes P, plus an optional valid flag and a running prime-hit count.

Parameters:
- WIDTH, 5, operand width in bits; legal range 2..8.
- CNT_W, 16, width of the prime-hit counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  unsigned operand under test.
- A_valid  input  1  qualifies A; when low, A is ignored.
- P  output  1  registered primality flag for the last accepted A.
- P_valid  output  1  high for exactly the cycle after an accepted A.
- prime_cnt  output  CNT_W  number of accepted operands that were prime.

Behaviour:
- Reset (rst=1 at a rising edge):
  - P=0, P_valid=0, prime_cnt=0.
  - rst has priority over A_valid in the same cycle.
- Primality table:
  - The table has 2^WIDTH entries and is computed at elaboration by a constant function using trial division.
  - No runtime divider is used.
  - For WIDTH=5 the prime set is 2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31.
  - 0 and 1 are not prime.
- Latency: exactly 1 cycle.
  - On an edge with A_valid=1: P <= isprime(A), P_valid <= 1.
  - On an edge with A_valid=0: P holds its previous value, P_valid <= 0.
- Counter:
  - On an accepted prime A, prime_cnt increments by 1.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - Non-prime or invalid cycles leave it unchanged.
- A may change every cycle; back-to-back accepts are fully pipelined with no stall.
- X/unknown on A while A_valid=0 must not propagate to P or prime_cnt.
- Reset asserted mid-stream discards the in-flight result: P_valid=0 on the cycle after reset.

Decomposition:
- Shared package ten_pkg:
  - WIDTH default constant.
  - Constant function is_prime(int n), used to build the table.
  - Typedef for the operand (logic [WIDTH-1:0]).
- One natural sub-module, ten_prime_rom:
  - Combinational lookup, A to raw prime bit, holding the 2^WIDTH-entry constant table.
  - The top module holds the output register, valid pipeline and saturating counter.

Test Plan:
- Reset: hold rst=1 for 2 cycles with A_valid=1 and A=7 -> P=0, P_valid=0, prime_cnt=0 throughout.
- Exhaustive sweep: A=0..31 with A_valid=1, one per cycle.
  - P is 1 one cycle after A is one of 2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, and 0 otherwise.
  - prime_cnt=11 after the sweep.
- Boundaries:
  - A=0 -> P=0.
  - A=1 -> P=0.
  - A=2 -> P=1.
  - A=31 -> P=1.
  - A=25 -> P=0 (composite square).
- Valid gating:
  - Apply A=13 with A_valid=0 -> P_valid=0 and prime_cnt unchanged.
  - Then apply A=13 with A_valid=1 -> next cycle P=1, P_valid=1, prime_cnt+1.
- Counter saturation: build with CNT_W=2 and feed 5 primes -> prime_cnt stops at 3.
- Mid-stream reset:
  - Accept A=29, then assert rst in the next cycle -> P_valid=0 and prime_cnt=0.
  - Afterwards, A=4 -> P=0.
